// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and register-count derivation for regfile_sb
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    function automatic int num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits, busy population count and stall
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] read_reg_a,
    input  logic [ADDR_W-1:0] read_reg_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NUM_REGS = num_regs(ADDR_W);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     count_next;
    logic                write_live;
    logic                issue_live;

    assign write_live = write_en && (write_reg != '0);
    assign issue_live = issue_en && (issue_reg != '0);

    // Issue is applied after writeback so a same-index pair leaves the new producer pending.
    always_comb begin
        busy_next = busy;
        if (write_live) busy_next[write_reg] = 1'b0;
        if (issue_live) busy_next[issue_reg] = 1'b1;
        busy_next[0] = 1'b0;
        count_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    // A bypassed read is not busy unless the same index is being re-issued this cycle.
    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        if (read_reg_a != '0) begin
            if (write_live && (write_reg == read_reg_a))
                busy_a = issue_live && (issue_reg == read_reg_a);
            else
                busy_a = busy[read_reg_a];
        end
        if (read_reg_b != '0) begin
            if (write_live && (write_reg == read_reg_b))
                busy_b = issue_live && (issue_reg == read_reg_b);
            else
                busy_b = busy[read_reg_b];
        end
    end

    assign stall = busy_a || busy_b || (issue_live && busy[issue_reg]);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read one-write register file with write bypass and issue scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              ctrl_issueEnable,
    input  logic [ADDR_W-1:0] ctrl_issueReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              busy_readRegA,
    output logic              busy_readRegB,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NUM_REGS = num_regs(ADDR_W);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (ctrl_writeEnable && (ctrl_writeReg != '0)) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Index 0 is hardwired to zero, so it never bypasses.
    always_comb begin
        data_readRegA = regs[ctrl_readRegA];
        data_readRegB = regs[ctrl_readRegB];
        if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
        if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
        if (ctrl_readRegA == '0) data_readRegA = '0;
        if (ctrl_readRegB == '0) data_readRegB = '0;
    end

    regfile_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .write_en   (ctrl_writeEnable),
        .write_reg  (ctrl_writeReg),
        .issue_en   (ctrl_issueEnable),
        .issue_reg  (ctrl_issueReg),
        .read_reg_a (ctrl_readRegA),
        .read_reg_b (ctrl_readRegB),
        .busy_a     (busy_readRegA),
        .busy_b     (busy_readRegB),
        .stall      (stall),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-driven self-checking bench for regfile_sb
module tb_regfile_sb;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        busy_readRegA;
    logic        busy_readRegB;
    logic        stall;
    logic [5:0]  busy_count;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks;
    int   n_fail;

    logic [31:0] model_regs [32];
    logic [31:0] model_busy;

    regfile_sb dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_issueEnable (ctrl_issueEnable),
        .ctrl_issueReg    (ctrl_issueReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .busy_readRegA    (busy_readRegA),
        .busy_readRegB    (busy_readRegB),
        .stall            (stall),
        .busy_count       (busy_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ctrl_writeEnable = 1'b0;
        ctrl_issueEnable = 1'b0;
        ctrl_writeReg    = '0;
        ctrl_issueReg    = '0;
        data_writeReg    = '0;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        idle();
        step();
        step();
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd31;
        sb_q.push_back('{"reset_rd_a", 32'h0});
        sb_q.push_back('{"reset_rd_b", 32'h0});
        sb_q.push_back('{"reset_busy_count", 32'h0});
        sb_q.push_back('{"reset_stall", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegB !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegB, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, stall, e.val); end
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h1111_2222;
        ctrl_readRegA    = 5'd9;
        sb_q.push_back('{"reset_bypass_rd_a", 32'h1111_2222});
        #1;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
        step();
        ctrl_reset = 1'b0;
        idle();
        sb_q.push_back('{"reset_dominates_write", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
    endtask

    task automatic test_write_read();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hDEAD_BEEF;
        ctrl_readRegA    = 5'd0;
        step();
        idle();
        ctrl_readRegA = 5'd5;
        sb_q.push_back('{"wr_rd_r5_data", 32'hDEAD_BEEF});
        sb_q.push_back('{"wr_rd_r5_busy", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_readRegA) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, busy_readRegA, e.val); end
    endtask

    task automatic test_reg0();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h1234_5678;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        sb_q.push_back('{"r0_bypass_a", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
        step();
        idle();
        ctrl_issueEnable = 1'b1;
        ctrl_issueReg    = 5'd0;
        sb_q.push_back('{"r0_rd_a", 32'h0});
        sb_q.push_back('{"r0_rd_b", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegB !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegB, e.val); end
        step();
        idle();
        sb_q.push_back('{"r0_issue_count", 32'h0});
        sb_q.push_back('{"r0_busy_a", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_readRegA) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, busy_readRegA, e.val); end
    endtask

    task automatic test_bypass();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'hA5A5_A5A5;
        ctrl_readRegB    = 5'd7;
        sb_q.push_back('{"bypass_rd_b", 32'hA5A5_A5A5});
        sb_q.push_back('{"bypass_busy_b", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegB !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegB, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_readRegB) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, busy_readRegB, e.val); end
        step();
        idle();
        ctrl_readRegB = 5'd0;
    endtask

    task automatic test_scoreboard();
        ctrl_issueEnable = 1'b1;
        ctrl_issueReg    = 5'd3;
        step();
        idle();
        ctrl_readRegA = 5'd3;
        sb_q.push_back('{"sb_busy_a", 32'h1});
        sb_q.push_back('{"sb_stall", 32'h1});
        sb_q.push_back('{"sb_count_1", 32'h1});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_readRegA) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, busy_readRegA, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, stall, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h0000_0042;
        sb_q.push_back('{"sb_wb_bypass_busy_a", 32'h0});
        sb_q.push_back('{"sb_wb_bypass_stall", 32'h0});
        #1;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_readRegA) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, busy_readRegA, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, stall, e.val); end
        step();
        idle();
        sb_q.push_back('{"sb_wb_count_0", 32'h0});
        sb_q.push_back('{"sb_wb_data", 32'h0000_0042});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
    endtask

    task automatic test_issue_on_busy();
        ctrl_issueEnable = 1'b1;
        ctrl_issueReg    = 5'd3;
        ctrl_readRegA    = 5'd0;
        step();
        sb_q.push_back('{"reissue_stall", 32'h1});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, stall, e.val); end
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h0000_0099;
        ctrl_readRegA    = 5'd3;
        sb_q.push_back('{"issue_wb_same_busy_a", 32'h1});
        #1;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_readRegA) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, busy_readRegA, e.val); end
        step();
        idle();
        sb_q.push_back('{"issue_wb_data", 32'h0000_0099});
        sb_q.push_back('{"issue_wb_busy_a", 32'h1});
        sb_q.push_back('{"issue_wb_count", 32'h1});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_readRegA) !== e.val) begin n_fail++; $display("FAIL %s got %b expected %0d", e.name, busy_readRegA, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h0000_0100;
        step();
        ctrl_writeReg    = 5'd4;
        data_writeReg    = 32'hCAFE_F00D;
        step();
        idle();
        ctrl_readRegA = 5'd4;
        sb_q.push_back('{"wb_nonbusy_count", 32'h0});
        sb_q.push_back('{"wb_nonbusy_data", 32'hCAFE_F00D});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        e = sb_q.pop_front(); n_checks++;
        if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.name, data_readRegA, e.val); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        ctrl_reset = 1'b1;
        idle();
        step();
        ctrl_reset = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_busy = '0;
        for (int it = 0; it < 60; it++) begin
            ctrl_writeEnable = 1'($urandom_range(0, 1));
            ctrl_writeReg    = 5'($urandom_range(0, 31));
            data_writeReg    = $urandom;
            ctrl_issueEnable = 1'($urandom_range(0, 1));
            ctrl_issueReg    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : 5'($urandom_range(0, 31));
            if (ctrl_writeEnable && ctrl_writeReg != 0) begin
                model_regs[ctrl_writeReg] = data_writeReg;
                model_busy[ctrl_writeReg] = 1'b0;
            end
            if (ctrl_issueEnable && ctrl_issueReg != 0) model_busy[ctrl_issueReg] = 1'b1;
            step();
            idle();
            ctrl_readRegA = 5'($urandom_range(0, 31));
            cnt = 0;
            for (int i = 1; i < 32; i++) cnt += int'(model_busy[i]);
            sb_q.push_back('{"b2b_rd_a", model_regs[ctrl_readRegA]});
            sb_q.push_back('{"b2b_busy_a", 32'(model_busy[ctrl_readRegA])});
            sb_q.push_back('{"b2b_count", 32'(cnt)});
            #2;
            e = sb_q.pop_front(); n_checks++;
            if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s it=%0d got %h expected %h", e.name, it, data_readRegA, e.val); end
            e = sb_q.pop_front(); n_checks++;
            if (32'(busy_readRegA) !== e.val) begin n_fail++; $display("FAIL %s it=%0d got %b expected %0d", e.name, it, busy_readRegA, e.val); end
            e = sb_q.pop_front(); n_checks++;
            if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s it=%0d got %0d expected %0d", e.name, it, busy_count, e.val); end
        end
    endtask

    task automatic test_fill_reset();
        for (int i = 1; i < 32; i++) begin
            ctrl_issueEnable = 1'b1;
            ctrl_issueReg    = 5'(i);
            step();
        end
        idle();
        sb_q.push_back('{"fill_count_31", 32'd31});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        ctrl_reset = 1'b1;
        step();
        ctrl_reset = 1'b0;
        sb_q.push_back('{"fill_reset_count", 32'h0});
        #2;
        e = sb_q.pop_front(); n_checks++;
        if (32'(busy_count) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.name, busy_count, e.val); end
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            sb_q.push_back('{"fill_reset_rd_a", 32'h0});
            sb_q.push_back('{"fill_reset_busy_b", 32'h0});
            #1;
            e = sb_q.pop_front(); n_checks++;
            if (data_readRegA !== e.val) begin n_fail++; $display("FAIL %s r%0d got %h expected %h", e.name, i, data_readRegA, e.val); end
            e = sb_q.pop_front(); n_checks++;
            if (32'(busy_readRegB) !== e.val) begin n_fail++; $display("FAIL %s r%0d got %b expected %0d", e.name, 31 - i, busy_readRegB, e.val); end
            #1;
        end
    endtask

    initial begin
        clock         = 1'b0;
        ctrl_reset    = 1'b1;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        n_checks      = 0;
        n_fail        = 0;
        idle();
        test_reset();
        test_write_read();
        test_reg0();
        test_bypass();
        test_scoreboard();
        test_issue_on_busy();
        test_back_to_back();
        test_fill_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
